signal_pad_loader: RTL and testbench

- Streaming front end for the 1D conv receptive-field stage.
- Accepts one 16-bit sample per handshake and assembles a W-sample frame into a zero-padded register of W+2P samples.
- Presents the frame as one flat vector to the receptive-field selector and holds it stable until the downstream stage acknowledges.
- Supports back-to-back frames; handles short frames by zero-filling the remainder and flagging a length error.

---
 rtl/signal_pad_loader.sv | 151 +++++++++++++++
 tb/tb_signal_pad_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/signal_pad_loader.sv
// signal_pad_loader
//   Streaming front end for the 1D conv receptive-field stage. Collects W
//   samples, one per in_valid/in_ready handshake, into the middle of a
//   zero-padded frame of W+2P samples. The frame is held on `signal` with
//   frame_valid high until the consumer pulses frame_ack.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_data      incoming two's-complement sample
//   in_valid     in_data valid this cycle
//   in_last      final sample of the frame (qualified by in_valid)
//   in_ready     a sample is accepted this cycle if in_valid is also high
//   signal       padded frame, [0:N*DATA_WIDTH-1]; sample j at [j*DW +: DW]
//   frame_valid  signal holds a complete frame
//   frame_ack    consumer has taken the frame (ignored outside FULL)
//   len_error    current/last frame length was not W
module signal_pad_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int W          = 1024,
  parameter int P          = 28
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [0:(W+2*P)*DATA_WIDTH-1]     signal,
  output logic                              frame_valid,
  input  logic                              frame_ack,
  output logic                              len_error
);

  localparam int N     = W + 2*P;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_len_err, w_len_err_nxt;
  logic                   w_we;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic                   w_last_slot;

  // cnt points at the data slot (relative to P) written this cycle
  assign w_last_slot = (r_cnt == CNT_W'(W-1));

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len_err <= w_len_err_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state / outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_len_err_nxt = r_len_err;
    in_ready      = 1'b0;
    frame_valid   = 1'b0;
    w_we          = 1'b0;
    w_wdata       = '0;

    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_we      = 1'b1;
          w_wdata   = in_data;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_last_slot) begin
            // W samples arrived; a missing in_last is still a length error
            w_state_nxt = S_FULL;
            if (!in_last) w_len_err_nxt = 1'b1;
          end else if (in_last) begin
            // short frame: zero the rest of the data region
            w_len_err_nxt = 1'b1;
            w_state_nxt   = S_FILL;
          end
        end
      end

      S_FILL: begin
        // w_wdata stays zero; one slot per cycle
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_last_slot) w_state_nxt = S_FULL;
      end

      S_FULL: begin
        frame_valid = 1'b1;
        if (frame_ack) begin
          w_state_nxt   = S_LOAD;
          w_cnt_nxt     = '0;
          w_len_err_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign len_error = r_len_err;

  // ---------------------------------------------------------------------
  // Frame storage. Only the W data slots are registers; the pads on both
  // sides are tied to zero. Each slot decodes its own write enable.
  // ---------------------------------------------------------------------
  assign signal[0 +: P*DATA_WIDTH]                 = '0;
  assign signal[(P+W)*DATA_WIDTH +: P*DATA_WIDTH]  = '0;

  for (genvar i = 0; i < W; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_slot;

    always_ff @(posedge clk) begin
      if (reset)
        r_slot <= '0;
      else if (w_we && (r_cnt == CNT_W'(i)))
        r_slot <= w_wdata;
    end

    assign signal[(P+i)*DATA_WIDTH +: DATA_WIDTH] = r_slot;
  end

  // N kept for readers sizing the output vector
  localparam int SIG_BITS = N * DATA_WIDTH;
  if (SIG_BITS != $bits(signal)) begin : g_size_chk
    $error("signal width mismatch");
  end

endmodule

// File: tb/tb_signal_pad_loader.sv
module tb_signal_pad_loader;
  localparam int DW = 16;
  localparam int W  = 1024;
  localparam int P  = 28;
  localparam int N  = W + 2*P;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     in_data;
  logic              in_valid, in_last, in_ready;
  logic [0:N*DW-1]   sig;
  logic              frame_valid, frame_ack, len_error;

  signal_pad_loader #(.DATA_WIDTH(DW), .W(W), .P(P)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .signal(sig), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .len_error(len_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [N];

  typedef struct {
    int          n;        // samples offered
    bit          last;     // in_last on final sample
    bit          cmode;    // 1: constant cval, 0: ramp k+1
    logic [15:0] cval;
    int          duty;     // percent of cycles with in_valid
    bit          exp_err;
    int          spot_slot;
    logic [15:0] spot_val;
  } frame_vec_t;

  frame_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] slot(input int j);
    logic [DW-1:0] v;
    v = sig[j*DW +: DW];
    return v;
  endfunction

  task automatic check_contents(input string name);
    int bad = 0;
    int first = -1;
    for (int j = 0; j < N; j++)
      if (slot(j) !== exp_mem[j]) begin
        bad++;
        if (first < 0) first = j;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad slots, slot %0d got %0h expected %0h",
               name, bad, first, slot(first), exp_mem[first]);
    end
  endtask

  task automatic clear_model();
    for (int j = 0; j < N; j++) exp_mem[j] = '0;
  endtask

  // Offer v.n samples; returns accepts and cycles where frame_valid was seen
  task automatic send_frame(input frame_vec_t v, output int acc, output int fv_seen);
    int k = 0;
    int cyc = 0;
    bit go, took;
    fv_seen = 0;
    while (k < v.n && cyc < 20000) begin
      go       = ($urandom_range(0, 99) < v.duty);
      in_valid = go;
      in_data  = v.cmode ? v.cval : DW'(k + 1);
      in_last  = v.last && (k == v.n - 1);
      took     = go && in_ready;
      if (frame_valid) fv_seen++;
      step();
      if (took) begin
        exp_mem[P+k] = in_data;
        k++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc = k;
    if (v.n < W)
      for (int j = v.n; j < W; j++) exp_mem[P+j] = '0;
  endtask

  // Count cycles after the last accept until frame_valid, tracking in_ready
  task automatic wait_full(output int fill_obs, output int ready_hi);
    fill_obs = 0;
    ready_hi = 0;
    while (!frame_valid && fill_obs < 2000) begin
      fill_obs++;
      if (in_ready) ready_hi++;
      step();
    end
  endtask

  // Hold in FULL with in_valid driven, then ack and check release
  task automatic hold_and_ack(input string tag);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    in_last  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      chk({tag, "_full_ready_low"}, {31'd0, in_ready}, 32'd0);
      step();
      chk({tag, "_full_hold_valid"}, {31'd0, frame_valid}, 32'd1);
    end
    check_contents({tag, "_no_overwrite"});
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk({tag, "_ack_fv_low"},     {31'd0, frame_valid}, 32'd0);
    chk({tag, "_ack_ready_high"}, {31'd0, in_ready},    32'd1);
    chk({tag, "_ack_lenerr_clr"}, {31'd0, len_error},   32'd0);
  endtask

  initial begin
    int acc, fvs, fill, rhi;
    frame_vec_t rv;

    //            n     last cmode cval      duty err spot  val
    vecs[0] = '{1024, 1'b1, 1'b0, 16'h0000, 100, 1'b0, 1051, 16'h0400};
    vecs[1] = '{1024, 1'b1, 1'b1, 16'hFFFF, 100, 1'b0,   28, 16'hFFFF};
    vecs[2] = '{  10, 1'b1, 1'b1, 16'h1234, 100, 1'b1,   38, 16'h0000};
    vecs[3] = '{1024, 1'b0, 1'b0, 16'h0000, 100, 1'b1, 1051, 16'h0400};
    vecs[4] = '{1024, 1'b1, 1'b0, 16'h0000,  30, 1'b0,   28, 16'h0001};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; frame_ack = 1'b0;
    clear_model();
    repeat (3) step();
    reset = 1'b0;
    chk("rst_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_fv",     {31'd0, frame_valid}, 32'd0);
    chk("rst_lenerr", {31'd0, len_error},   32'd0);
    chk("rst_sig_zero", {31'd0, |sig},      32'd0);

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("f%0d", i);
      send_frame(vecs[i], acc, fvs);
      chk({tag, "_accepts"}, acc, vecs[i].n);
      chk({tag, "_fv_during_load"}, fvs, 0);
      wait_full(fill, rhi);
      chk({tag, "_fill_cycles"}, fill, W - vecs[i].n);
      chk({tag, "_fill_ready_low"}, rhi, 0);
      chk({tag, "_fv"}, {31'd0, frame_valid}, 32'd1);
      chk({tag, "_lenerr"}, {31'd0, len_error}, {31'd0, vecs[i].exp_err});
      chk({tag, "_spot"}, {16'd0, slot(vecs[i].spot_slot)}, {16'd0, vecs[i].spot_val});
      chk({tag, "_pad_lo"}, {16'd0, slot(P-1)}, 32'd0);
      chk({tag, "_pad_hi"}, {16'd0, slot(P+W)}, 32'd0);
      check_contents({tag, "_contents"});
      hold_and_ack(tag);
    end

    // frame 0 boundary slots by hand: ramp 1..1024 after ack is gone, so
    // replay a plain frame and look at the edges of the data region
    send_frame(vecs[0], acc, fvs);
    wait_full(fill, rhi);
    chk("edge_slot0",    {16'd0, slot(0)},    32'd0);
    chk("edge_slot28",   {16'd0, slot(28)},   32'h0001);
    chk("edge_slot1051", {16'd0, slot(1051)}, 32'h0400);
    chk("edge_slot1079", {16'd0, slot(1079)}, 32'd0);
    hold_and_ack("edge");

    // reset in the middle of a frame, then a full fresh frame
    rv = '{500, 1'b0, 1'b0, 16'h0000, 100, 1'b0, 0, 16'h0000};
    send_frame(rv, acc, fvs);
    chk("mid_accepts", acc, 500);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_model();
    chk("mid_rst_ready",    {31'd0, in_ready},    32'd1);
    chk("mid_rst_fv",       {31'd0, frame_valid}, 32'd0);
    chk("mid_rst_sig_zero", {31'd0, |sig},        32'd0);
    rv = '{1024, 1'b1, 1'b1, 16'h5A5A, 100, 1'b0, 0, 16'h0000};
    send_frame(rv, acc, fvs);
    chk("post_rst_accepts", acc, 1024);
    chk("post_rst_fv_early", fvs, 0);
    wait_full(fill, rhi);
    chk("post_rst_fill", fill, 0);
    chk("post_rst_fv", {31'd0, frame_valid}, 32'd1);
    check_contents("post_rst_contents");
    hold_and_ack("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
